// File: rtl/adc_cfg_pkg.sv
// Shared types and defaults for the ADC config sequencer.
package adc_cfg_pkg;
  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_LAUNCH, ST_WAIT, ST_CAPTURE
  } state_e;

  localparam logic [15:0] INIT_WAIT_DEF   = 16'h3F10;
  localparam logic [7:0]  XFER_CYCLES_DEF = 8'd48;
  localparam int          RD_BIT_LO       = 15;
  localparam int          RD_BIT_HI       = 31;

  function automatic logic is_rd_op(input logic [31:0] w);
    return w[RD_BIT_LO] | w[RD_BIT_HI];
  endfunction
endpackage

// File: rtl/adc_cfg_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with occupancy count.
module adc_cfg_cmd_fifo #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic          clk_sck,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push, pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  // Accept is judged on the pre-pop occupancy.
  assign push    = wr_i & ~full_o;
  assign pop     = rd_i & ~empty_o;

  always_ff @(posedge clk_sck) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/adc_cfg_sequencer.sv
// Buffers host config words and feeds them one at a time to the ADC serial
// config engine, capturing readback of read commands for the host.
module adc_cfg_sequencer
  import adc_cfg_pkg::*;
#(
  parameter int          CMD_AW      = 3,
  parameter logic [15:0] INIT_WAIT   = INIT_WAIT_DEF,
  parameter logic [7:0]  XFER_CYCLES = XFER_CYCLES_DEF
) (
  input  logic              clk_sck,
  input  logic              rst_n,
  input  logic              cmd_wr,
  input  logic [31:0]       cmd_data,
  output logic              cmd_full,
  output logic [CMD_AW:0]   cmd_level,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  input  logic              rd_ack,
  output logic              busy,
  output logic [1:0]        err_ovf,
  input  logic              err_clr,
  output logic [31:0]       adc_cfg_data,
  output logic              en_adc_cfg,
  input  logic [15:0]       adc_cfg_rb
);
  state_e      state_q;
  logic [15:0] init_cnt_q;
  logic [7:0]  xfer_cnt_q;
  logic [31:0] cfg_data_q;
  logic [15:0] rd_data_q;
  logic        en_q, rd_op_q, rd_valid_q, run_q;
  logic [1:0]  err_q, err_d;
  logic        fifo_empty, fifo_pop, capture_rd;
  logic [31:0] fifo_head;

  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign capture_rd = (state_q == ST_CAPTURE) && rd_op_q;

  adc_cfg_cmd_fifo #(.W(32), .AW(CMD_AW)) u_fifo (
    .clk_sck (clk_sck),
    .rst_n   (rst_n),
    .wr_i    (cmd_wr),
    .wdata_i (cmd_data),
    .rd_i    (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (cmd_full),
    .empty_o (fifo_empty),
    .level_o (cmd_level)
  );

  // A same-cycle rd_ack means the host already took the old value: no overwrite error.
  always_comb begin
    err_d = err_q | {capture_rd & rd_valid_q & ~rd_ack, cmd_wr & cmd_full};
    if (err_clr) err_d = '0;
  end

  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      xfer_cnt_q <= '0;
      cfg_data_q <= '0;
      rd_data_q  <= '0;
      en_q       <= 1'b0;
      rd_op_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      run_q <= 1'b1;
      err_q <= err_d;
      en_q  <= 1'b0;
      if (rd_ack) rd_valid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q >= INIT_WAIT - 16'd1) state_q <= ST_IDLE;
          else init_cnt_q <= init_cnt_q + 16'd1;
        end
        ST_IDLE: begin
          if (fifo_pop) begin
            cfg_data_q <= fifo_head;
            en_q       <= 1'b1;
            rd_op_q    <= is_rd_op(fifo_head);
            state_q    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          xfer_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (xfer_cnt_q >= XFER_CYCLES - 8'd1) state_q <= ST_CAPTURE;
          else xfer_cnt_q <= xfer_cnt_q + 8'd1;
        end
        ST_CAPTURE: begin
          if (rd_op_q) begin
            rd_data_q  <= adc_cfg_rb;
            rd_valid_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign adc_cfg_data = cfg_data_q;
  assign en_adc_cfg   = en_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign err_ovf      = err_q;
  // run_q keeps busy low in the reset cycle even though the state is INIT.
  assign busy         = run_q & ((state_q != ST_IDLE) | ~fifo_empty);
endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed + randomized bench for adc_cfg_sequencer against a transaction-level model.
module tb_adc_cfg_sequencer;
  localparam int INIT_WAIT = 16'h3F10;
  localparam int XFER      = 48;
  localparam int DEPTH     = 8;

  logic        clk_sck = 1'b0;
  logic        rst_n, cmd_wr, rd_ack, err_clr;
  logic [31:0] cmd_data;
  logic [15:0] adc_cfg_rb;
  logic        cmd_full, rd_valid, busy, en_adc_cfg;
  logic [3:0]  cmd_level;
  logic [15:0] rd_data;
  logic [1:0]  err_ovf;
  logic [31:0] adc_cfg_data;

  always #5 clk_sck = ~clk_sck;

  adc_cfg_sequencer dut (
    .clk_sck(clk_sck), .rst_n(rst_n), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .cmd_full(cmd_full), .cmd_level(cmd_level), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ack(rd_ack), .busy(busy), .err_ovf(err_ovf), .err_clr(err_clr),
    .adc_cfg_data(adc_cfg_data), .en_adc_cfg(en_adc_cfg), .adc_cfg_rb(adc_cfg_rb)
  );

  int checks = 0, failures = 0;
  int n = 0;
  // Model: accepted words in order; the engine is free once n > idle_start.
  logic [31:0] q[$];
  int          launch_edge[$];
  logic [31:0] launch_word[$];
  int          idle_start = 1 << 30, cap_edge = -1, rst_edge = 0;
  logic        cap_rd = 1'b0, en_exp = 1'b0, busy_exp = 1'b0, rdv_exp = 1'b0;
  logic [31:0] data_exp = '0;
  logic [15:0] rdd_exp = '0, rb_force = '0;
  logic        rb_force_en = 1'b0;
  logic [1:0]  err_exp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    int         lvl;
    logic       launch;
    logic [1:0] new_err;
    logic [31:0] w;
    @(posedge clk_sck);
    n++;
    #1;
    en_exp = 1'b0;
    if (!rst_n) begin
      q.delete();
      idle_start = n + INIT_WAIT;
      rst_edge = n;
      cap_edge = -1;
      data_exp = '0; rdv_exp = 1'b0; rdd_exp = '0; err_exp = '0; busy_exp = 1'b0;
    end else begin
      lvl = q.size();
      new_err = '0;
      launch = (n > idle_start) && (lvl > 0);
      if (cmd_wr) begin
        if (lvl < DEPTH) q.push_back(cmd_data);
        else new_err[0] = 1'b1;
      end
      if (launch) begin
        w = q.pop_front();
        data_exp = w;
        en_exp = 1'b1;
        idle_start = n + XFER + 2;
        cap_edge = n + XFER + 2;
        cap_rd = w[15] | w[31];
        launch_edge.push_back(n);
        launch_word.push_back(w);
      end
      if (n == cap_edge && cap_rd) begin
        if (rdv_exp && !rd_ack) new_err[1] = 1'b1;
        rdv_exp = 1'b1;
        rdd_exp = adc_cfg_rb;
      end else if (rd_ack) rdv_exp = 1'b0;
      err_exp = err_clr ? 2'b00 : (err_exp | new_err);
      busy_exp = (n < idle_start) || (q.size() > 0);
    end
    chk("en_adc_cfg", 32'(en_adc_cfg), 32'(en_exp));
    chk("adc_cfg_data", adc_cfg_data, data_exp);
    chk("cmd_level", 32'(cmd_level), 32'(q.size()));
    chk("cmd_full", 32'(cmd_full), 32'(q.size() == DEPTH));
    chk("busy", 32'(busy), 32'(busy_exp));
    chk("rd_valid", 32'(rd_valid), 32'(rdv_exp));
    chk("rd_data", 32'(rd_data), 32'(rdd_exp));
    chk("err_ovf", 32'(err_ovf), 32'(err_exp));
    if (en_exp) begin
      adc_cfg_rb = rb_force_en ? rb_force : 16'($urandom);
      rb_force_en = 1'b0;
    end
  endtask

  task automatic wait_launches(input int target, input int bound);
    int b = bound;
    while (launch_word.size() < target && b > 0) begin
      step();
      b--;
    end
    chk("launch_timeout", 32'(launch_word.size() >= target), 32'd1);
  endtask

  task automatic rand_traffic(input int cycles, input int wr_pct);
    for (int i = 0; i < cycles; i++) begin
      cmd_wr   = ($urandom_range(99) < wr_pct);
      cmd_data = $urandom;
      if ($urandom_range(1) == 1) cmd_data = cmd_data & 32'h7FFF_7FFF;
      rd_ack   = ($urandom_range(99) < 10);
      err_clr  = ($urandom_range(199) == 0);
      step();
    end
    cmd_wr = 1'b0; rd_ack = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] burst [9];
    int d, pe, base, b;
    rst_n = 1'b0; cmd_wr = 1'b0; cmd_data = '0; rd_ack = 1'b0; err_clr = 1'b0; adc_cfg_rb = '0;
    step(); step();
    rst_n = 1'b1;

    // Single write during INIT: one pulse once the power-up window ends.
    repeat (4) step();
    cmd_wr = 1'b1; cmd_data = 32'h0000_0165; step(); cmd_wr = 1'b0;
    wait_launches(1, INIT_WAIT + 20);
    d = (launch_edge.size() > 0) ? launch_edge[0] - rst_edge : 0;
    chk("t1_launch_window", 32'((d >= INIT_WAIT + 1) && (d <= INIT_WAIT + 3)), 32'd1);
    chk("t1_word", adc_cfg_data, 32'h0000_0165);
    repeat (60) step();
    chk("t1_no_rd_valid", 32'(rd_valid), 32'd0);
    chk("t1_one_pulse", 32'(launch_word.size()), 32'd1);

    // Read command: rd_valid is first seen XFER+1 cycles after the pulse cycle ends.
    rb_force = 16'hA55A; rb_force_en = 1'b1;
    cmd_wr = 1'b1; cmd_data = 32'h8100_8000; step(); cmd_wr = 1'b0;
    wait_launches(2, 20);
    pe = n;
    b = 100;
    while (!rd_valid && b > 0) begin step(); b--; end
    chk("t2_rd_latency", 32'(n - pe), 32'(XFER + 2));
    chk("t2_rd_data", 32'(rd_data), 32'h0000_A55A);
    rd_ack = 1'b1; step(); rd_ack = 1'b0;
    chk("t2_ack_clears", 32'(rd_valid), 32'd0);

    // Two reads with no ack: second capture overwrites.
    for (int i = 0; i < 2; i++) begin
      cmd_wr = 1'b1; cmd_data = $urandom | 32'h0000_8000; step();
    end
    cmd_wr = 1'b0;
    repeat (2 * (XFER + 3) + 10) step();
    chk("t4_rb_overwrite", 32'(err_ovf), 32'd2);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_err_clr", 32'(err_ovf), 32'd0);
    rd_ack = 1'b1; step(); rd_ack = 1'b0;

    rand_traffic(3000, 5);
    repeat (9 * (XFER + 3)) step();

    // Burst of 9 during INIT: 8 accepted, 9th dropped, served back-to-back in order.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    base = launch_word.size();
    step();
    for (int i = 0; i < 9; i++) begin
      burst[i] = $urandom;
      cmd_wr = 1'b1; cmd_data = burst[i]; step();
      if (i == 7) chk("t3_full_after_8", 32'(cmd_full), 32'd1);
    end
    cmd_wr = 1'b0;
    chk("t3_drop_err", 32'(err_ovf), 32'd1);
    chk("t3_level", 32'(cmd_level), 32'd8);
    wait_launches(base + 8, INIT_WAIT + 9 * (XFER + 3));
    for (int i = 0; i < 8; i++) begin
      if (launch_word.size() > base + i) begin
        chk("t3_order", launch_word[base + i], burst[i]);
        if (i > 0) chk("t3_spacing", 32'(launch_edge[base + i] - launch_edge[base + i - 1]), 32'(XFER + 3));
      end
    end

    // Reset in the middle of WAIT with commands still queued.
    for (int i = 0; i < 3; i++) begin
      cmd_wr = 1'b1; cmd_data = $urandom; step();
    end
    cmd_wr = 1'b0;
    wait_launches(base + 9, 200);
    repeat (20) step();
    rst_n = 1'b0; step();
    chk("t5_en_low", 32'(en_adc_cfg), 32'd0);
    chk("t5_fifo_empty", 32'(cmd_level), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    rst_n = 1'b1;
    base = launch_word.size();

    // Fill during INIT, then write into a full FIFO on the first IDLE pop.
    step();
    for (int i = 0; i < 8; i++) begin
      cmd_wr = 1'b1; cmd_data = $urandom; step();
    end
    cmd_wr = 1'b0;
    chk("t6_full", 32'(cmd_full), 32'd1);
    while (n < idle_start) step();
    chk("t5_no_pulse_in_init", 32'(launch_word.size()), 32'(base));
    cmd_wr = 1'b1; cmd_data = $urandom; step(); cmd_wr = 1'b0;
    chk("t6_level_8_to_7", 32'(cmd_level), 32'd7);
    chk("t6_drop_err", 32'(err_ovf[0]), 32'd1);
    chk("t6_pulse", 32'(en_adc_cfg), 32'd1);
    chk("t5_reinit_time", 32'(n - rst_edge), 32'(INIT_WAIT + 1));

    rand_traffic(1500, 4);
    repeat (9 * (XFER + 3)) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_cfg_sequencer.md
Name: adc_cfg_sequencer

Overview:
- Upstream feeder for the ADC serial-config engine, which has a one-shot en_adc_cfg strobe, a static 32-bit command word and a 16-bit readback.
- Buffers host (PCIe BAR) config words in a small command FIFO and waits out the ADC power-up window.
- Launches one config transaction at a time, holding the word stable for the whole transaction.
- After a fixed transaction time, captures the 16-bit readback of read commands into a host-visible holding register.

Parameters:
- CMD_AW, 3: command FIFO address width; depth = 2**CMD_AW = 8.
- INIT_WAIT, 16'h3F10: cycles after reset before the first launch. Exceeds the config engine's 24'h3F00 power-up gate.
- XFER_CYCLES, 8'd48: cycles from en_adc_cfg pulse to readback sample. The engine needs 2 x 21 cycles plus a 1-cycle output register; the rest is margin.

Ports:
- clk_sck  in  1  config clock (same clock as the serial engine)
- rst_n  in  1  synchronous active-low reset
- cmd_wr  in  1  host write strobe, one word per cycle
- cmd_data  in  32  host config word; bit15/bit31 set = read half
- cmd_full  out  1  FIFO holds 2**CMD_AW words
- cmd_level  out  CMD_AW+1  FIFO occupancy
- rd_valid  out  1  readback holding register valid
- rd_data  out  16  captured readback {hi byte, lo byte}
- rd_ack  in  1  host consumed rd_data
- busy  out  1  not in IDLE, or FIFO non-empty
- err_ovf  out  2  sticky: [0] command dropped on full, [1] readback overwritten
- err_clr  in  1  clears err_ovf
- adc_cfg_data  out  32  word to engine, held until next launch
- en_adc_cfg  out  1  1-cycle launch pulse to engine
- adc_cfg_rb  in  16  engine readback (adc_cfg_data_o)

Behaviour:
- Reset values (rst_n=0 at posedge): all outputs 0, FIFO empty, state INIT, wait counter 0. Reset mid-transaction aborts immediately; en_adc_cfg=0 in the same cycle.
- FSM states and transitions:
  - INIT: count to INIT_WAIT-1, then go to IDLE. Commands are accepted into the FIFO during INIT.
  - IDLE: if FIFO non-empty, pop and go to LAUNCH. The FIFO read is first-word-fall-through.
  - LAUNCH (1 cycle): adc_cfg_data <= popped word; en_adc_cfg=1 this cycle only; store rd_op = word[15]|word[31]; go to WAIT.
  - WAIT: count 0..XFER_CYCLES-1, then go to CAPTURE. adc_cfg_data is stable throughout.
  - CAPTURE (1 cycle): if rd_op, rd_data <= adc_cfg_rb and rd_valid <= 1. Go to IDLE.
- Minimum launch-to-launch spacing: XFER_CYCLES+3 cycles.
- Command FIFO:
  - A write is accepted iff cmd_full=0, judged before any pop in the same cycle.
  - A write while full is dropped and sets err_ovf[0].
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap mod 2**CMD_AW. Level is CMD_AW+1 bits.
- Readback register:
  - rd_ack clears rd_valid the next cycle.
  - CAPTURE with rd_valid=1 and no rd_ack that cycle overwrites rd_data and sets err_ovf[1].
  - CAPTURE together with rd_ack in the same cycle: the capture wins, rd_valid stays 1, no error.
  - Write commands leave rd_data and rd_valid untouched.
- err_clr has priority over a new error set in the same cycle.
- Arithmetic: counters are unsigned. The WAIT counter is 8 bits and the INIT counter 16 bits; both saturate and never wrap.

Decomposition:
- Shared package adc_cfg_pkg:
  - FSM state enum (INIT, IDLE, LAUNCH, WAIT, CAPTURE).
  - Default INIT_WAIT and XFER_CYCLES constants.
  - RD_BIT_LO=15 and RD_BIT_HI=31.
- One natural sub-module: adc_cfg_cmd_fifo, a synchronous FWFT FIFO parameterised by width and CMD_AW, with full/empty/level outputs.

Test Plan:
- Reset, then write 32'h0000_0165 at cycle 5 -> en_adc_cfg pulses exactly once at cycle INIT_WAIT+2 (±1 for FWFT); adc_cfg_data=32'h0000_0165; rd_valid stays 0.
- After INIT, write read command 32'h8100_8000; model adc_cfg_rb=16'hA55A -> rd_valid=1 and rd_data=16'hA55A exactly XFER_CYCLES+1 cycles after the pulse.
- Burst 9 writes while in INIT -> cmd_full=1 after the 8th; 9th dropped; err_ovf=2'b01; exactly 8 pulses later, spaced XFER_CYCLES+3 apart, in write order.
- Two read commands, rd_ack never asserted -> second capture overwrites rd_data and sets err_ovf[1]; err_clr returns err_ovf to 0.
- Assert rst_n=0 in mid-WAIT -> all outputs 0 next cycle; FIFO empty; no en_adc_cfg pulse until a full INIT_WAIT elapses again.
- Full FIFO with cmd_wr in the same cycle as the IDLE pop -> write dropped, err_ovf[0]=1, cmd_level goes 8 -> 7.
